// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: operand, handshake and HI/LO bus between the issue logic
// (master) and the iterative multiply/divide unit (slave).
// Optional feature macro: MULDIV_ABORT_EN adds the abort request line.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
    logic             abort;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata, abort,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata, abort,
        output busy, done, dbz, hi, lo
    );
`else
    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, dbz, hi, lo
    );
`endif
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative mult/multu/div/divu unit owning the HI/LO registers.
// Sequence per op: launch (latch magnitudes and result signs), one load cycle
// plus WIDTH shift-add or restoring-divide steps, one sign-fix cycle that
// commits HI/LO with a done pulse. mthi/mtlo writes are taken only while idle.
// Optional feature macro: MULDIV_ABORT_EN adds bus.abort to cancel an op in flight.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_hilo_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    // Magnitude of a two's complement operand; unsigned ops pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] m;
        m = v;
        if (is_signed && v[WIDTH-1]) m = -m;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] src_a_s;
    logic signed [WIDTH-1:0] src_b_s;
    logic                    op_signed;
    assign src_a_s   = bus.src_a;
    assign src_b_s   = bus.src_b;
    assign op_signed = ~bus.op[0];

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    // acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc holds {remainder, dividend bits -> quotient bits}.
    logic [WIDTH:0]       div_top;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_step;
    assign div_top  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = (div_top >= {1'b0, mag_b_q});
    assign div_rem  = div_top[WIDTH-1:0] - mag_b_q;
    assign div_step = {(div_ge ? div_rem : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // State register and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            raw_a_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            raw_a_q   <= raw_a_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state and datapath: launch, load/iterate, sign fix and commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        raw_a_d   = raw_a_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d      = bus.op;
                    raw_a_d   = bus.src_a;
                    mag_a_d   = magnitude(src_a_s, op_signed);
                    mag_b_d   = magnitude(src_b_s, op_signed);
                    neg_res_d = op_signed & (src_a_s[WIDTH-1] ^ src_b_s[WIDTH-1]);
                    neg_rem_d = op_signed & src_a_s[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = bus.op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                // First cycle loads the multiplier; the next WIDTH cycles iterate.
                if (cnt_q == '0) acc_d = {{WIDTH{1'b0}}, mag_b_q};
                else             acc_d = mul_step;
                if (cnt_q == CNT_LAST) state_d = FIX;
                cnt_d = cnt_q + CNT_ONE;
            end
            DIV: begin
                // First cycle loads the dividend; the next WIDTH cycles iterate.
                if (cnt_q == '0) acc_d = {{WIDTH{1'b0}}, mag_a_q};
                else             acc_d = div_step;
                if (cnt_q == CNT_LAST) state_d = FIX;
                cnt_d = cnt_q + CNT_ONE;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q[1]) begin
                    if (mag_b_q == '0) begin
                        hi_d  = raw_a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        // Most-negative / -1 falls out naturally as 0x80..0 with zero remainder.
                        lo_d = cond_neg_w(acc_q[WIDTH-1:0], neg_res_q);
                        hi_d = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                    end
                end else begin
                    {hi_d, lo_d} = cond_neg_2w(acc_q, neg_res_q);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MULDIV_ABORT_EN
        // Abort wins over everything once an op is in flight, including FIX.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: self-checking bench for muldiv_hilo. A transaction-level
// reference (plain arithmetic results delivered WIDTH+2 edges after launch)
// is compared against busy/done/dbz/hi/lo every cycle, plus literal checks.
// Optional feature macro: MULDIV_ABORT_EN (abort scenarios).
module tb_muldiv_hilo;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_hilo_if #(.WIDTH(WIDTH)) bus ();
    muldiv_hilo #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result: {dbz, hi, lo}.
    function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint            sp;
        logic [63:0]       p;
        logic signed [31:0] q, r;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, 64'(sp)};
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, r, q};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Reference state: remaining edges of the op in flight and the pending result.
    int          m_rem;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dbz;
    logic [64:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_rem == 0) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
                if (bus.start) begin
                    m_pend <= ref_result(bus.op, bus.src_a, bus.src_b);
                    m_rem  <= WIDTH + 2;
                end
            end
`ifdef MULDIV_ABORT_EN
            else if (bus.abort) begin
                m_rem <= 0;
            end
`endif
            else begin
                if (m_rem == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                    m_dbz  <= m_pend[64];
                end
                m_rem <= m_rem - 1;
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("busy", 65'(bus.busy), 65'(m_rem != 0));
        chk("done", 65'(bus.done), 65'(m_done));
        chk("dbz",  65'(bus.dbz),  65'(m_dbz));
        chk("hi",   65'(bus.hi),   65'(m_hi));
        chk("lo",   65'(bus.lo),   65'(m_lo));
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic quiet();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 65'(bus.busy), 65'd0);
    endtask

    // Launch an op and return one step after the done edge; lat = edges to done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int n = 0;
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.op    = 2'($urandom);
        while (!bus.done && n < WIDTH + 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 65'(bus.done), 65'd1);
        lat = n;
    endtask

    initial begin
        int lat;
        int n;
        quiet();
        bus.op    = 2'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.wdata = '0;

        // Reference model pinned to hand-computed values.
        chk("ref_multu", ref_result(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
        chk("ref_mult",  ref_result(2'd0, 32'hFFFF_FFF9, 32'd3), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        chk("ref_div",   ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        chk("ref_divu0", ref_result(2'd3, 32'd100, 32'd0), {1'b1, 64'h0000_0064_FFFF_FFFF});
        chk("ref_ovf",   ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 65'(bus.busy), 65'd0);
        chk("rst_hi",   65'(bus.hi),   65'd0);
        chk("rst_lo",   65'(bus.lo),   65'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_lat", 65'(lat), 65'(WIDTH + 2));
        chk("multu_hi", 65'(bus.hi), 65'hFFFF_FFFE);
        chk("multu_lo", 65'(bus.lo), 65'h0000_0001);
        @(posedge clk); #1;
        chk("done_pulse", 65'(bus.done), 65'd0);

        run_op(2'd0, 32'hFFFF_FFF9, 32'd3, lat);
        chk("mult_hi", 65'(bus.hi), 65'hFFFF_FFFF);
        chk("mult_lo", 65'(bus.lo), 65'hFFFF_FFEB);

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_lo", 65'(bus.lo), 65'hFFFF_FFFD);
        chk("div_hi", 65'(bus.hi), 65'hFFFF_FFFF);

        run_op(2'd3, 32'd100, 32'd0, lat);
        chk("dbz_lat", 65'(lat), 65'(WIDTH + 2));
        chk("dbz_flag", 65'(bus.dbz), 65'd1);
        chk("dbz_hi", 65'(bus.hi), 65'd100);
        chk("dbz_lo", 65'(bus.lo), 65'hFFFF_FFFF);

        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("ovf_lo", 65'(bus.lo), 65'h8000_0000);
        chk("ovf_hi", 65'(bus.hi), 65'd0);
        chk("ovf_dbz", 65'(bus.dbz), 65'd0);

        // mthi while idle, then writes and a second start while busy are ignored.
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("mthi", 65'(bus.hi), 65'h1234);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 60) begin
            if (n == 5) begin
                bus.hi_we = 1'b1;
                bus.wdata = 32'h5555;
                bus.start = 1'b1;
                bus.op    = 2'd3;
                bus.src_a = 32'd100;
                bus.src_b = 32'd7;
            end else begin
                bus.hi_we = 1'b0;
                bus.start = 1'b0;
            end
            n++;
            @(posedge clk); #1;
        end
        quiet();
        chk("busy_cycles", 65'(n), 65'(WIDTH + 2));
        chk("ign_done", 65'(bus.done), 65'd1);
        chk("ign_hi", 65'(bus.hi), 65'd0);
        chk("ign_lo", 65'(bus.lo), 65'd6);
        @(posedge clk); #1;
        chk("no_queue", 65'(bus.busy), 65'd0);

        // Asynchronous reset in the middle of divu 9/2.
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.src_a = 32'd9;
        bus.src_b = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 65'(bus.busy), 65'd0);
        chk("arst_hi", 65'(bus.hi), 65'd0);
        chk("arst_lo", 65'(bus.lo), 65'd0);
        chk("arst_done", 65'(bus.done), 65'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(2'd3, 32'd9, 32'd2, lat);
        chk("divu_lo", 65'(bus.lo), 65'd4);
        chk("divu_hi", 65'(bus.hi), 65'd1);

`ifdef MULDIV_ABORT_EN
        wait_idle();
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hAAAA;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", 65'(bus.busy), 65'd0);
        chk("abort_hi", 65'(bus.hi), 65'hAAAA);
        chk("abort_lo", 65'(bus.lo), 65'hAAAA);
        run_op(2'd0, 32'd3, 32'd4, lat);
        chk("after_abort_lo", 65'(bus.lo), 65'd12);
        chk("after_abort_hi", 65'(bus.hi), 65'd0);
`endif

        // Randomized traffic: starts, ignored starts, mthi/mtlo, aborts, one reset.
        for (int i = 0; i < 5000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom);
            bus.src_a = pick();
            bus.src_b = pick();
            bus.hi_we = ($urandom_range(0, 7) == 0);
            bus.lo_we = ($urandom_range(0, 7) == 0);
            bus.wdata = $urandom;
`ifdef MULDIV_ABORT_EN
            bus.abort = ($urandom_range(0, 63) == 0);
`endif
            if (i == 2500) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        quiet();
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
